// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multicycle RV32M multiply/divide unit.
// Holds the func3 encodings, the FSM state type and operand signedness helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] f);
    case (f)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: op_signed_a = 1'b1;
      default:                            op_signed_a = 1'b0;
    endcase
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM only.
  function automatic logic op_signed_b(input logic [2:0] f);
    case (f)
      F3_MULH, F3_DIV, F3_REM: op_signed_b = 1'b1;
      default:                 op_signed_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_multicycle_if.sv
// muldiv_multicycle_if: request/response bundle between an issuing unit
// (master) and the multicycle multiply/divide unit (slave).
interface muldiv_multicycle_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output start, func3, op_a, op_b,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, func3, op_a, op_b,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the 2*XLEN working register.
// Multiply: LSB-first shift-add (upper half accumulates, register shifts right).
// Divide (only with MULDIV_DIV_EN): restoring shift-subtract; upper half is the
// partial remainder, lower half collects quotient bits from the right.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] w_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] w_o
);

  logic [XLEN:0]     sum_s;
  logic [2*XLEN-1:0] mul_w_s;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     rem_ext_s;
  logic [XLEN:0]     diff_s;
`endif

  // Single-iteration datapath: add-or-pass for multiply, subtract-and-restore for divide.
  always_comb begin
    sum_s   = {1'b0, w_i[2*XLEN-1:XLEN]} + (w_i[0] ? {1'b0, b_i} : {(XLEN+1){1'b0}});
    mul_w_s = {sum_s, w_i[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // Shift the next dividend bit into the partial remainder and trial-subtract.
    rem_ext_s = w_i[2*XLEN-1:XLEN-1];
    diff_s    = rem_ext_s - {1'b0, b_i};
    if (!is_div_i) begin
      w_o = mul_w_s;
    end else if (!diff_s[XLEN]) begin
      w_o = {diff_s[XLEN-1:0], w_i[XLEN-2:0], 1'b1};
    end else begin
      w_o = {rem_ext_s[XLEN-1:0], w_i[XLEN-2:0], 1'b0};
    end
`else
    // No divider in this build; the divide state is never entered.
    if (is_div_i) begin
      w_o = {(2*XLEN){1'b0}};
    end else begin
      w_o = mul_w_s;
    end
`endif
  end

endmodule

// File: rtl/muldiv_multicycle.sv
// muldiv_multicycle: iterative RV32M multiply/divide unit, one bit per cycle.
// Operands are latched as magnitudes; sign correction is applied in FIX.
// Build option: define MULDIV_DIV_EN to include the divide/remainder datapath;
// without it, DIV/DIVU/REM/REMU complete in two cycles with illegal=1, result=0.
module muldiv_multicycle
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  muldiv_multicycle_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [2*XLEN-1:0] w_q, w_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              ill_op_q, ill_op_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;

  logic              in_neg_a_s, in_neg_b_s;
  logic [XLEN-1:0]   in_abs_a_s, in_abs_b_s;
  logic [2*XLEN-1:0] step_w_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_result_s;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (state_q == ST_DIV),
    .w_i      (w_q),
    .b_i      (b_q),
    .w_o      (step_w_s)
  );

  // Incoming operand magnitudes according to the requested op's signedness.
  always_comb begin
    in_neg_a_s = op_signed_a(bus.func3) & bus.op_a[XLEN-1];
    in_neg_b_s = op_signed_b(bus.func3) & bus.op_b[XLEN-1];
    in_abs_a_s = in_neg_a_s ? ({XLEN{1'b0}} - bus.op_a) : bus.op_a;
    in_abs_b_s = in_neg_b_s ? ({XLEN{1'b0}} - bus.op_b) : bus.op_b;
  end

  // Sign correction and half/quotient/remainder selection for the FIX state.
  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? ({(2*XLEN){1'b0}} - w_q) : w_q;
    quot_s = (neg_a_q ^ neg_b_q) ? ({XLEN{1'b0}} - w_q[XLEN-1:0]) : w_q[XLEN-1:0];
    rem_s  = neg_a_q ? ({XLEN{1'b0}} - w_q[2*XLEN-1:XLEN]) : w_q[2*XLEN-1:XLEN];
    if (ill_op_q) begin
      fix_result_s = {XLEN{1'b0}};
    end else begin
      case (func3_q)
        F3_MUL:                       fix_result_s = prod_s[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: fix_result_s = prod_s[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:              fix_result_s = quot_s;
        F3_REM, F3_REMU:              fix_result_s = rem_s;
        default:                      fix_result_s = {XLEN{1'b0}};
      endcase
    end
  end

  // FSM next-state, datapath loads and output register updates.
  always_comb begin
    state_d   = state_q;
    func3_d   = func3_q;
    w_d       = w_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    ill_op_d  = ill_op_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          func3_d  = bus.func3;
          cnt_d    = {CW{1'b0}};
          neg_a_d  = in_neg_a_s;
          neg_b_d  = in_neg_b_s;
          w_d      = {{XLEN{1'b0}}, in_abs_a_s};
          b_d      = in_abs_b_s;
          ill_op_d = 1'b0;
          if (!bus.func3[2]) begin
            state_d = ST_MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            if (bus.op_b == {XLEN{1'b0}}) begin
              // Divide by zero: preload remainder=op_a, quotient=all-ones, no sign fix.
              w_d     = {bus.op_a, {XLEN{1'b1}}};
              neg_a_d = 1'b0;
              neg_b_d = 1'b0;
              state_d = ST_FIX;
            end else begin
              state_d = ST_DIV;
            end
`else
            ill_op_d = 1'b1;
            state_d  = ST_FIX;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        w_d   = step_w_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = state_q;
        end
      end
      ST_FIX: begin
        result_d  = fix_result_s;
        illegal_d = ill_op_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      func3_q   <= 3'b000;
      w_q       <= {(2*XLEN){1'b0}};
      b_q       <= {XLEN{1'b0}};
      cnt_q     <= {CW{1'b0}};
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      ill_op_q  <= 1'b0;
      result_q  <= {XLEN{1'b0}};
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      func3_q   <= func3_d;
      w_q       <= w_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      ill_op_q  <= ill_op_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_multicycle.sv
// tb_muldiv_multicycle: directed self-checking bench with an expected-result queue.
module tb_muldiv_multicycle;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   extra;
  exp_t sb_q[$];

  muldiv_multicycle_if #(.XLEN(XLEN)) mif ();

  muldiv_multicycle #(.XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one op (called mid-cycle), wait for done with a bound, then compare.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ei, input int el,
                        input string tag, input bit inject);
    exp_t e;
    exp_t got;
    int   lat;
    int   bcnt;
    e.tag = tag; e.res = er; e.ill = ei; e.lat = el;
    sb_q.push_back(e);
    mif.func3 = f; mif.op_a = a; mif.op_b = b; mif.start = 1'b1;
    @(posedge clock); #1;
    mif.start = 1'b0; mif.func3 = 3'b111; mif.op_a = 32'hA5A5_5A5A; mif.op_b = 32'h0000_0000;
    lat = 0; bcnt = 0;
    while (mif.done !== 1'b1 && lat < 200) begin
      if (mif.busy === 1'b1) bcnt++;
      if (inject && lat == 3) begin
        mif.start = 1'b1; mif.func3 = F3_MUL; mif.op_a = 32'd5; mif.op_b = 32'd5;
      end
      if (inject && lat == 5) mif.start = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    got = sb_q.pop_front();
    chk({got.tag, "/result"}, mif.result, got.res);
    chk({got.tag, "/illegal"}, {31'd0, mif.illegal}, {31'd0, got.ill});
    chk({got.tag, "/latency"}, 32'(lat), 32'(got.lat));
    chk({got.tag, "/busy_cycles"}, 32'(bcnt), 32'(got.lat));
    chk({got.tag, "/busy_at_done"}, {31'd0, mif.busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    mif.start = 1'b0; mif.func3 = 3'b000; mif.op_a = 32'd0; mif.op_b = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset/busy", {31'd0, mif.busy}, 32'd0);
    chk("reset/done", {31'd0, mif.done}, 32'd0);
    chk("reset/result", mif.result, 32'd0);
    chk("reset/illegal", {31'd0, mif.illegal}, 32'd0);

    // First start is taken on the first rising edge after reset release.
    @(negedge clock);
    reset = 1'b1;
    run_op(F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, "mul",    1'b0);
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, "mulhu",  1'b0);
    run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33, "mulh",   1'b0);
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, "mulhsu", 1'b0);
    run_op(F3_MULH,   32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33, "mulh_neg", 1'b0);
`ifdef MULDIV_DIV_EN
    run_op(F3_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33, "div",      1'b0);
    run_op(F3_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33, "rem",      1'b0);
    run_op(F3_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 33, "divu",     1'b0);
    run_op(F3_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 33, "remu",     1'b0);
    run_op(F3_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1,  "div0",     1'b0);
    run_op(F3_REM,  32'd5,         32'd0,         32'd5,         1'b0, 1,  "rem0",     1'b0);
    run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, "div_ovf",  1'b0);
    run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 33, "rem_ovf",  1'b0);
`else
    run_op(F3_DIV,  32'd10,        32'd2,         32'd0,         1'b1, 1,  "div_ill",  1'b0);
    run_op(F3_REMU, 32'd100,       32'd7,         32'd0,         1'b1, 1,  "remu_ill", 1'b0);
`endif
    run_op(F3_MUL,  32'd3,         32'd4,         32'd12,        1'b0, 33, "mul_after", 1'b0);

    // Start pulsed while busy must be ignored: one done, result unchanged afterwards.
    run_op(F3_MUL,  32'd3,         32'd4,         32'd12,        1'b0, 33, "ignore",   1'b1);
    extra = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (mif.done === 1'b1) extra++;
    end
    chk("ignore/extra_done", 32'(extra), 32'd0);
    chk("hold/result", mif.result, 32'd12);

    // Reset in the middle of a multiply aborts it without a done pulse.
    mif.start = 1'b1; mif.func3 = F3_MUL; mif.op_a = 32'd9; mif.op_b = 32'd9;
    @(posedge clock); #1;
    mif.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset/busy", {31'd0, mif.busy}, 32'd0);
    chk("midreset/done", {31'd0, mif.done}, 32'd0);
    chk("midreset/result", mif.result, 32'd0);
    chk("midreset/illegal", {31'd0, mif.illegal}, 32'd0);
    extra = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (mif.done === 1'b1) extra++;
    end
    chk("midreset/abort_done", 32'(extra), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op(F3_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33, "post_reset", 1'b0);

    chk("scoreboard/empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_multicycle.md
MULDIV_MULTICYCLE -- requirements
Module: muldiv_multicycle

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width (any even value >= 8).
REQ-002 Ports: clock  input  1  single clock, all state updates on rising edge.
REQ-003 Ports: reset  input  1  asynchronous, active-low; clears all state.
REQ-004 Ports: start  input  1  request; accepted only when busy=0.
REQ-005 Ports: func3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Ports: op_a  input  XLEN  rs1 value (multiplicand/dividend).
REQ-007 Ports: op_b  input  XLEN  rs2 value (multiplier/divisor).
REQ-008 Ports: busy  output  1  operation in progress.
REQ-009 Ports: done  output  1  one-cycle pulse, result valid.
REQ-010 Ports: result  output  XLEN  final value, held until next accepted start.
REQ-011 Ports: illegal  output  1  op not supported in this build, valid with done.

Function
REQ-012 States SHALL be IDLE, MUL, DIV, FIX; busy=1 in MUL, DIV, FIX.
REQ-013 IDLE: start=1 latches func3, |op_a|, |op_b| (sign-magnitude per op signedness), result sign; goes to MUL (func3[2]=0) or DIV (func3[2]=1).
REQ-014 MUL: radix-2 shift-add, one bit per cycle, exactly XLEN cycles, 2*XLEN-bit unsigned product, then FIX.
REQ-015 DIV: restoring shift-subtract, one quotient bit per cycle, exactly XLEN cycles, then FIX.
REQ-016 FIX: applies sign correction, selects low (MUL) or high (MULH*) half, quotient (DIV*) or remainder (REM*); drives result, pulses done, returns to IDLE.
REQ-017 Latency: start accepted at edge E0 -> done=1 during cycle after edge E0+XLEN+1; busy falls at same edge.
REQ-018 Signedness: MULH both signed; MULHSU op_a signed, op_b unsigned; DIV/REM signed; MULHU/DIVU/REMU unsigned.
REQ-019 Divide by zero: skip DIV, go directly to FIX; quotient all-ones, remainder op_a; done after edge E0+1.
REQ-020 Signed overflow (op_a = most-negative, op_b = -1): quotient = op_a, remainder 0; full latency.
REQ-021 Remainder sign SHALL equal dividend sign; quotient truncates toward zero.
REQ-022 start while busy=1 SHALL be ignored; inputs need not be held after acceptance.
REQ-023 start in the done cycle SHALL be accepted (back-to-back, busy=0 in that cycle).

Reset
REQ-024 reset low at any time, including mid-operation: state IDLE, busy=0, done=0, illegal=0, result=0, all internal registers 0; no done pulse for the aborted op.
REQ-025 First start accepted on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined: divide/remainder datapath and DIV state built; all eight ops supported, illegal always 0.
REQ-027 MULDIV_DIV_EN undefined: no divider logic; func3[2]=1 goes IDLE->FIX, done after edge E0+1 with result=0, illegal=1; multiply ops unchanged.

Structure
REQ-028 Package muldiv_pkg SHALL hold func3 encoding constants and the state enumeration typedef.
REQ-029 One sub-module muldiv_step: combinational single-iteration step (add-or-pass for MUL, subtract-and-restore for DIV) on the 2*XLEN-bit working register; FSM, counter, sign fix stay in top.

Verification (XLEN=32)
REQ-030 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done 33 cycles after start edge, busy high 33 cycles.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, done at second cycle; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-034 start MUL, reset low at cycle 10, release, start MUL 3x4 -> no done for first op, result 12; start pulsed while busy -> ignored, single done.
REQ-035 Build without MULDIV_DIV_EN: DIV 10/2 -> illegal=1, result 0, done at second cycle; MUL 3x4 -> 12, illegal=0.
